hex_disp_scan: RTL and testbench



---
 rtl/hex_disp_scan.sv | 247 ++++++++++++++++++++++++
 tb/tb_hex_disp_scan.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_disp_scan.sv
`default_nettype none
// ============================================================================
// Module   : hex_disp_scan
// Purpose  : Time-multiplexed scanner for an 8-digit common-anode
//            seven-segment display. One digit is driven per slot. Each slot
//            opens with a blanking dead-time to suppress ghosting. The
//            input word is snapshotted once per frame so a refresh never
//            tears.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   REFRESH_DIV   clock cycles per digit slot (2 .. 2**20)
//   BLANK_CYC     dead-time cycles at the start of each slot
//                 (1 <= BLANK_CYC < REFRESH_DIV)
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_en           scan enable; low keeps the display dark
//   i_hex_disp     32-bit word, nibble k shown on digit k (digit 0 rightmost)
//   i_dp_mask      decimal-point enable per digit
//   o_an           anode enables, active-low
//   o_seg          segments {g,f,e,d,c,b,a}, active-low
//   o_dp           decimal point, active-low
//   o_frame_start  one-cycle pulse whenever a new snapshot is taken
// Build option:
//   HEX_SCAN_LZ_BLANK_EN  when defined, digits above the most significant
//                         non-zero nibble stay dark (leading-zero suppression)
// ============================================================================
module hex_disp_scan #(
  parameter int REFRESH_DIV = 12500,
  parameter int BLANK_CYC   = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [31:0] i_hex_disp,
  input  logic [7:0]  i_dp_mask,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       C_DIGIT_LAST = 3'd7;

  // Elaboration-time parameter sanity checks
  generate
    if ((REFRESH_DIV < 2) || (REFRESH_DIV > (1 << 20))) begin : g_chk_refresh
      $error("hex_disp_scan: REFRESH_DIV out of range");
    end
    if ((BLANK_CYC < 1) || (BLANK_CYC >= REFRESH_DIV)) begin : g_chk_blank
      $error("hex_disp_scan: BLANK_CYC out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_digit;
  logic [2:0]       w_digit_nxt;
  logic [31:0]      r_snap_hex;
  logic [7:0]       r_snap_dp;
  logic             w_capture;
  logic             w_digit_vis;
  logic [3:0]       w_nibble;
  logic [7:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;

  // Hex to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // --------------------------------------------------------------------------
  // State register and frame snapshot
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_digit    <= '0;
      r_snap_hex <= '0;
      r_snap_dp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_digit <= w_digit_nxt;
      if (w_capture) begin
        r_snap_hex <= i_hex_disp;
        r_snap_dp  <= i_dp_mask;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. The slot counter runs 0..REFRESH_DIV-1 across both
  // BLANK and DRIVE; BLANK owns the first BLANK_CYC counts.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_digit_nxt = r_digit;
    w_capture   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt   = '0;
        w_digit_nxt = '0;
        if (i_en) begin
          w_state_nxt = ST_BLANK;
          w_capture   = 1'b1;
        end
      end

      ST_BLANK: begin
        if (!i_en) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_digit_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
          if (r_cnt == C_BLANK_LAST) begin
            w_state_nxt = ST_DRIVE;
          end
        end
      end

      ST_DRIVE: begin
        if (!i_en) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_digit_nxt = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_digit_nxt = r_digit + 3'd1;
          // Wrapping back to digit 0 starts a new frame
          w_capture   = (r_digit == C_DIGIT_LAST);
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_digit_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Leading-zero suppression: the most significant non-zero nibble index is
  // latched together with the snapshot so it stays coherent with the frame.
  // --------------------------------------------------------------------------
`ifdef HEX_SCAN_LZ_BLANK_EN
  logic [2:0] r_msd;
  logic [2:0] w_msd_in;

  always_comb begin
    w_msd_in = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (i_hex_disp[k*4 +: 4] != 4'h0) begin
        w_msd_in = 3'(k);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_msd <= 3'd0;
    end else if (w_capture) begin
      r_msd <= w_msd_in;
    end
  end

  assign w_digit_vis = (w_digit_nxt <= r_msd);
`else
  assign w_digit_vis = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Registered outputs, computed from the upcoming state so they line up with
  // it. Entering DRIVE never coincides with a capture, so the current
  // snapshot is the one to display.
  // --------------------------------------------------------------------------
  assign w_nibble = r_snap_hex[{w_digit_nxt, 2'b00} +: 4];

  always_comb begin
    w_an_nxt  = 8'hFF;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if ((w_state_nxt == ST_DRIVE) && w_digit_vis) begin
      w_an_nxt  = ~(8'h01 << w_digit_nxt);
      w_seg_nxt = seg_decode(w_nibble);
      w_dp_nxt  = ~r_snap_dp[w_digit_nxt];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_an          <= 8'hFF;
      o_seg         <= 7'h7F;
      o_dp          <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      o_an          <= w_an_nxt;
      o_seg         <= w_seg_nxt;
      o_dp          <= w_dp_nxt;
      o_frame_start <= w_capture;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_disp_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_disp_scan
// Purpose  : Self-checking bench for hex_disp_scan. A timeline model predicts
//            every output cycle into a queue; a negedge monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_disp_scan;

  localparam int R = 8;
  localparam int B = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic [31:0] i_hex_disp;
  logic [7:0]  i_dp_mask;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame_start;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  localparam exp_t DARK = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_disp_scan #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_hex_disp    (i_hex_disp),
    .i_dp_mask     (i_dp_mask),
    .o_an          (o_an),
    .o_seg         (o_seg),
    .o_dp          (o_dp),
    .o_frame_start (o_frame_start)
  );

  always #10 i_clk = ~i_clk;

  // --------------------------------------------------------------------------
  // Reference model: time t counts cycles since the scan started; slot, digit
  // and blank phase follow from plain division of t.
  // --------------------------------------------------------------------------
  bit          m_run;
  bit          m_cap;
  int          m_t;
  int          m_dig;
  int          m_msd;
  bit          m_show;
  logic [31:0] m_hex;
  logic [7:0]  m_dp;
  logic [3:0]  m_nib;
  exp_t        m_e;

  initial begin
    m_run = 0; m_t = 0; m_hex = '0; m_dp = '0; m_msd = 0;
    forever begin
      @(posedge i_clk);
      m_cap = 0;
      if (!i_rst_n) begin
        m_run = 0;
      end else if (!m_run) begin
        if (i_en) begin
          m_run = 1; m_t = 0; m_cap = 1;
        end
      end else if (!i_en) begin
        m_run = 0;
      end else begin
        m_t = m_t + 1;
        if (m_t % (8 * R) == 0) m_cap = 1;
      end
      if (m_cap) begin
        m_hex = i_hex_disp;
        m_dp  = i_dp_mask;
        m_msd = 0;
        for (int k = 0; k < 8; k++) if (m_hex[k*4 +: 4] != 4'h0) m_msd = k;
      end
      m_e    = DARK;
      m_e.fs = m_cap;
      if (m_run && (m_t % R) >= B) begin
        m_dig  = (m_t / R) % 8;
        m_show = 1;
`ifdef HEX_SCAN_LZ_BLANK_EN
        m_show = (m_dig <= m_msd);
`endif
        if (m_show) begin
          m_nib    = m_hex[m_dig*4 +: 4];
          m_e.an   = ~(8'h01 << m_dig);
          m_e.seg  = seg_tab[m_nib];
          m_e.dp   = ~m_dp[m_dig];
        end
      end
      exp_q.push_back(m_e);
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: one comparison per cycle, sampled on the falling edge
  // --------------------------------------------------------------------------
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge i_clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (!i_rst_n) mon_e = DARK;
        if ({o_an, o_seg, o_dp, o_frame_start} !== mon_e) begin
          errors++;
          $display("FAIL scan_out at %0t: got an=%h seg=%h dp=%b fs=%b, expected an=%h seg=%h dp=%b fs=%b",
                   $time, o_an, o_seg, o_dp, o_frame_start, mon_e.an, mon_e.seg, mon_e.dp, mon_e.fs);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic chk_dark(input string name);
    checks++;
    if ({o_an, o_seg, o_dp, o_frame_start} !== DARK) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b fs=%b, expected an=ff seg=7f dp=1 fs=0",
               name, o_an, o_seg, o_dp, o_frame_start);
    end
  endtask

  initial begin
    int n;
    i_rst_n    = 1'b0;
    i_en       = 1'b0;
    i_hex_disp = '0;
    i_dp_mask  = '0;
    cyc(3);
    chk_dark("reset_state");
    i_rst_n = 1'b1;
    cyc(2);

    // Basic scan, then an input change mid-frame must not show until the wrap
    i_hex_disp = 32'h1234567F;
    i_en       = 1'b1;
    cyc(20);
    i_hex_disp = 32'hFFFFFFFF;
    cyc(120);

    // Decimal points on digits 0 and 7 only
    i_en = 1'b0;
    cyc(2);
    i_dp_mask  = 8'h81;
    i_hex_disp = 32'h0;
    i_en       = 1'b1;
    cyc(70);

    // Drop enable during digit 3 DRIVE, then re-enable
    i_en = 1'b0;
    cyc(2);
    i_hex_disp = 32'h89ABCDEF;
    i_dp_mask  = 8'h0F;
    i_en       = 1'b1;
    cyc(3 * R + B + 4);
    i_en = 1'b0;
    cyc(3);
    i_en = 1'b1;
    cyc(20);

    // Asynchronous reset while a digit is lit
    n = 0;
    while (o_an == 8'hFF && n < 2 * R) begin
      cyc(1);
      n++;
    end
    checks++;
    if (o_an == 8'hFF) begin
      errors++;
      $display("FAIL drive_wait: got an=%h for %0d cycles, expected a lit digit", o_an, n);
    end
    #4;
    i_rst_n = 1'b0;
    i_en    = 1'b0;
    #1;
    chk_dark("async_reset");
    cyc(2);
    i_rst_n = 1'b1;
    cyc(4);
    i_en = 1'b1;
    cyc(20);

    // Leading-zero cases
    i_en = 1'b0;
    cyc(1);
    i_hex_disp = 32'h000000A5;
    i_dp_mask  = 8'h00;
    i_en       = 1'b1;
    cyc(70);
    i_en = 1'b0;
    cyc(1);
    i_hex_disp = 32'h0;
    i_dp_mask  = 8'hFF;
    i_en       = 1'b1;
    cyc(70);

    // Randomised runs with occasional mid-frame word changes and enable drops
    for (int it = 0; it < 30; it++) begin
      i_hex_disp = 32'($urandom) >> (4 * $urandom_range(0, 7));
      i_dp_mask  = 8'($urandom);
      i_en       = ($urandom_range(0, 5) != 0);
      n          = $urandom_range(1, 90);
      for (int j = 0; j < n; j++) begin
        cyc(1);
        if ($urandom_range(0, 15) == 0) i_hex_disp = 32'($urandom);
      end
    end

    i_en = 1'b0;
    cyc(3);
    @(negedge i_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
